oh_cell_bist: RTL and testbench

// Built-in self-test driver/checker for an N-input combinational standard cell
// (oh_nor2 and siblings). Drives every input vector onto the cell under test,

---
 rtl/oh_cell_bist.sv | 163 ++++++++++++++++
 tb/tb_oh_cell_bist.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_cell_bist.sv
`default_nettype none
// ============================================================================
//  Module      : oh_cell_bist
//  Description : Exhaustive-vector BIST driver/checker for a small combinational
//                cell. Sweeps all 2**N input vectors, samples the cell output
//                after a settle time and scores it against a truth table.
//  Revision    : 1.0  initial release
// ============================================================================
module oh_cell_bist #(
  parameter int                 N      = 2,
  parameter logic [(1<<N)-1:0]  TT     = 4'b0001,
  parameter int                 SETTLE = 2,
  parameter int                 REPEAT = 1,
  parameter int                 CW     = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          dut_z,
  output logic [N-1:0]  dut_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic          fail_valid,
  output logic [N-1:0]  fail_vec
);

  localparam int WW = $clog2(SETTLE + 1);
  localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [N-1:0]  VEC_LAST   = '1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'(REPEAT - 1);
  localparam logic [CW-1:0] ERR_MAX    = '1;
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(SETTLE);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [SW-1:0] sweep_q, sweep_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] err_q, err_d;
  logic          fail_valid_q, fail_valid_d;
  logic [N-1:0]  fail_vec_q, fail_vec_d;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    sweep_d      = sweep_q;
    wcnt_d       = wcnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          done_d       = 1'b0;
          vec_d        = '0;
          sweep_d      = '0;
          busy_d       = 1'b1;
          state_d      = S_DRIVE;
        end
      end

      S_DRIVE: begin
        wcnt_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wcnt_q <= WAIT_ONE) begin
          state_d = S_SAMPLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        if (dut_z != TT[vec_q]) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          // Only the first failing vector of a run is recorded.
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end

        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + 1'b1;
          state_d = S_DRIVE;
        end else if (sweep_q != SWEEP_LAST) begin
          vec_d   = '0;
          sweep_d = sweep_q + 1'b1;
          state_d = S_DRIVE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      sweep_q      <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      sweep_q      <= sweep_d;
      wcnt_q       <= wcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  // The vector register is the cell drive itself, so it changes on the same
  // edge that enters DRIVE and holds its last value through DONE.
  assign dut_in     = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_oh_cell_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oh_cell_bist
//  Description : Scoreboard bench for oh_cell_bist with a NOR2 cell model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oh_cell_bist;

  typedef struct {
    int err;
    int fv;
    int fvec;
    int pss;
    int lat;
  } res_t;

  typedef struct {
    int vec;
    int len;
  } seg_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       z_a;
  logic       z_b = 1'b1;

  logic [1:0] dut_in_a, fail_vec_a, dut_in_b, fail_vec_b;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q_a[$];
  res_t q_b[$];
  seg_t vq[$];
  bit   vchk = 1'b1;
  int   lat_a = 0, lat_b = 0;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0;
  logic [1:0] seg_vec = 2'd0;
  int   seg_len = 0;

  always #5 clk = ~clk;

  // mode 0: ideal NOR2, 1: output stuck-0, 2: output stuck-1
  always_comb begin
    z_a = 1'b0;
    case (mode)
      2'd0:    z_a = ~(dut_in_a[0] | dut_in_a[1]);
      2'd1:    z_a = 1'b0;
      default: z_a = 1'b1;
    endcase
  end

  oh_cell_bist dut_a (
    .clk(clk), .nreset(nreset), .start(start_a), .dut_z(z_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fail_valid_a), .fail_vec(fail_vec_a)
  );

  oh_cell_bist #(.CW(2), .REPEAT(2)) dut_b (
    .clk(clk), .nreset(nreset), .start(start_b), .dut_z(z_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e, input logic [31:0] err,
                         input logic [31:0] fv, input logic [31:0] fvec,
                         input logic [31:0] pss, input int lat);
    chk({tag, "_err_count"},  err,  e.err);
    chk({tag, "_fail_valid"}, fv,   e.fv);
    chk({tag, "_fail_vec"},   fvec, e.fvec);
    chk({tag, "_pass"},       pss,  e.pss);
    chk({tag, "_done_edge"},  lat,  e.lat);
  endtask

  // Monitors sample on the falling edge; inputs change 2ns after the rising edge.
  // Latency counts the accept edge as edge 1.
  always @(negedge clk) begin
    lat_a++;
    lat_b++;

    if (done_a && !prev_done_a) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_done: got done=1, expected no pending run");
      end else begin
        chk_res("a", q_a.pop_front(), err_a, fail_valid_a, fail_vec_a, pass_a, lat_a);
      end
    end
    if (done_b && !prev_done_b) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_done: got done=1, expected no pending run");
      end else begin
        chk_res("b", q_b.pop_front(), err_b, fail_valid_b, fail_vec_b, pass_b, lat_b);
      end
    end
    prev_done_a = done_a;
    prev_done_b = done_b;

    // Track how many busy cycles each drive vector is held for.
    if (busy_a) begin
      if (seg_len != 0 && dut_in_a != seg_vec) begin
        if (vchk) emit_seg();
        seg_len = 0;
      end
      seg_vec = dut_in_a;
      seg_len++;
    end else if (seg_len != 0) begin
      if (vchk) emit_seg();
      seg_len = 0;
    end

    if (start_a && !busy_a) lat_a = 0;
    if (start_b && !busy_b) lat_b = 0;
  end

  task automatic emit_seg();
    seg_t e;
    if (vq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL vec_unexpected: got vector %0d held %0d cycles, expected none", seg_vec, seg_len);
    end else begin
      e = vq.pop_front();
      chk("vec_value", seg_vec, e.vec);
      chk("vec_hold",  seg_len, e.len);
    end
  endtask

  task automatic pulse_a();
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 200 && !done_a; i++) @(negedge clk);
    chk({tag, "_done_reached"}, done_a, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_run_a(input int err, input int fv, input int fvec, input int pss);
    res_t r;
    r = '{err, fv, fvec, pss, 17};
    q_a.push_back(r);
    for (int v = 0; v < 4; v++) vq.push_back('{v, 4});
  endtask

  task automatic run_a(input string tag, input logic [1:0] m, input int err,
                       input int fv, input int fvec, input int pss, input bit repulse);
    mode = m;
    expect_run_a(err, fv, fvec, pss);
    pulse_a();
    if (repulse) begin
      repeat (4) @(posedge clk);
      #2 start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
    end
    wait_done_a(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_in"},     dut_in_a,     0);
    chk({tag, "_busy"},       busy_a,       0);
    chk({tag, "_done"},       done_a,       0);
    chk({tag, "_pass"},       pass_a,       0);
    chk({tag, "_err_count"},  err_a,        0);
    chk({tag, "_fail_valid"}, fail_valid_a, 0);
    chk({tag, "_fail_vec"},   fail_vec_a,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;

    #1 chk_zero("reset");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_err",  err_b,  0);
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;

    // T1 ideal NOR2: pass, no errors
    run_a("t1", 2'd0, 0, 0, 0, 1, 1'b0);
    // T2 stuck-0: vector 00 expects 1 -> one mismatch
    run_a("t2", 2'd1, 1, 1, 0, 0, 1'b0);
    // T3 stuck-1: vectors 01,10,11 expect 0 -> three mismatches
    run_a("t3", 2'd2, 3, 1, 1, 0, 1'b0);

    // T5 abort in the WAIT of vector 10, then a clean ideal run
    vchk = 1'b0;
    mode = 2'd0;
    pulse_a();
    for (int i = 0; i < 100 && dut_in_a != 2'd2; i++) @(negedge clk);
    chk("t5_reached_vec2", dut_in_a, 2);
    @(posedge clk); #2 nreset = 1'b0;
    #1 chk_zero("t5_async_reset");
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    repeat (2) @(negedge clk);
    vchk = 1'b1;
    run_a("t5", 2'd0, 0, 0, 0, 1, 1'b0);

    // T6 start re-pulsed while busy is ignored
    run_a("t6a", 2'd0, 0, 0, 0, 1, 1'b1);
    // T6 restart from DONE after a failing run clears the result
    run_a("t6_pre", 2'd1, 1, 1, 0, 0, 1'b0);
    mode = 2'd0;
    expect_run_a(0, 0, 0, 1);
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    chk("t6b_clear_err",  err_a,        0);
    chk("t6b_clear_fv",   fail_valid_a, 0);
    chk("t6b_clear_done", done_a,       0);
    chk("t6b_busy",       busy_a,       1);
    wait_done_a("t6b");

    // T4 CW=2, REPEAT=2, stuck-1: six mismatches saturate at 3
    r = '{3, 1, 1, 0, 33};
    q_b.push_back(r);
    @(posedge clk); #2 start_b = 1'b1;
    @(posedge clk); #2 start_b = 1'b0;
    for (int i = 0; i < 200 && !done_b; i++) @(negedge clk);
    chk("t4_done_reached", done_b, 1);
    chk("t4_dut_in_held", dut_in_b, 3);
    repeat (3) @(negedge clk);

    chk("sb_a_drained",   q_a.size(), 0);
    chk("sb_b_drained",   q_b.size(), 0);
    chk("sb_vec_drained", vq.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
